// File: rtl/syncfifo_pkg.sv
// Shared types and defaults for syncfifo and its write-side arbiter.
// Arbiter state encoding and the FIFO data width live here.
package syncfifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int FIFO_DW = 8;

endpackage

// File: rtl/syncfifo_wr_arb_rr_pick.sv
// Round-robin pick: first valid index at or after i_ptr, wrapping.
// Purely combinational; o_any flags that some requester is valid.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [PW:0]    w_sum;

  // Rotate so bit k of w_rot is requester (i_ptr + k) mod N
  assign w_dbl = {i_valid, i_valid};
  assign w_rot = w_dbl[i_ptr +: N];
  assign o_any = |w_rot;

  always_comb begin
    w_sum = '0;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = {1'b0, i_ptr} + (PW+1)'(k);
        if (w_sum >= (PW+1)'(N)) begin
          w_sum = w_sum - (PW+1)'(N);
        end
        o_idx = w_sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/syncfifo_wr_arb.sv
// Round-robin write-port arbiter placing NREQ producers onto syncfifo.
// Bounded bursts, stalls on full, releases on burst end or producer idle.
module syncfifo_wr_arb
  import syncfifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = FIFO_DW,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_write_en,
  output logic [DW-1:0]      fifo_data_in,
  output logic [NREQ-1:0]    grant,
  output logic               busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] r_rr_ptr;
  logic [CW-1:0] r_beat_cnt;

  logic [PW-1:0]   w_pick_idx;
  logic            w_pick_any;
  logic [NREQ-1:0] w_own_oh;
  logic [DW-1:0]   w_own_data;
  logic            w_busy;
  logic            w_own_valid;
  logic            w_accept;
  logic            w_last;
  logic            w_release;
  logic [PW-1:0]   w_next_ptr;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    w_own_oh   = '0;
    w_own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == PW'(i)) begin
        w_own_oh[i] = 1'b1;
        w_own_data  = req_data[i*DW +: DW];
      end
    end
  end

  assign w_busy      = (r_state == BUSY);
  assign w_own_valid = |(req_valid & w_own_oh);
  assign w_accept    = w_busy & w_own_valid & ~fifo_full;
  assign w_last      = w_accept &
                       (r_beat_cnt == CW'(MAX_BURST - 1));
  // An idle producer frees the port even while the FIFO is full
  assign w_release   = w_busy & (w_last | ~w_own_valid);
  assign w_next_ptr  = (r_owner == PW'(NREQ - 1)) ?
                       '0 : r_owner + PW'(1);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_pick_any) w_state_nxt = BUSY;
      BUSY: if (w_release)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_pick_any) begin
        r_owner    <= w_pick_idx;
        r_beat_cnt <= '0;
      end
      if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + CW'(1);
      end
      if (w_release) begin
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  assign busy          = w_busy;
  assign grant         = w_busy ? w_own_oh : '0;
  assign req_ready     = w_accept ? w_own_oh : '0;
  assign fifo_write_en = w_accept;
  assign fifo_data_in  = w_busy ? w_own_data : '0;

endmodule

// File: tb/tb_syncfifo_wr_arb.sv
// Directed bench for syncfifo_wr_arb with a queue standing in for syncfifo.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_syncfifo_wr_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_write_en;
  logic [7:0]  fifo_data_in;
  logic [3:0]  grant;
  logic        busy;

  int          n_chk;
  int          n_err;
  logic [7:0]  base [4];
  int          len  [4];
  int          pidx [4];
  logic [3:0]  last_rdy;
  logic [7:0]  wq [$];

  typedef struct {
    logic       rstn;
    logic [3:0] en;
    logic       full;
    logic [3:0] g;
    logic       b;
    logic       we;
    logic [7:0] d;
    logic [3:0] r;
  } vec_t;

  vec_t tv [11];

  always #5 clk = ~clk;

  syncfifo_wr_arb #(
    .NREQ      (4),
    .DW        (8),
    .MAX_BURST (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .grant         (grant),
    .busy          (busy)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm,
                         input logic [3:0] g, input logic b,
                         input logic we, input logic [7:0] d,
                         input logic [3:0] r);
    chk(nm, {14'd0, grant, busy, fifo_write_en, fifo_data_in, req_ready},
        {14'd0, g, b, we, d, r});
  endtask

  task automatic setup();
    for (int i = 0; i < 4; i++) begin
      base[i] = 8'h00;
      len[i]  = 255;
      pidx[i] = 0;
    end
    last_rdy = '0;
    wq.delete();
  endtask

  task automatic step(input logic [3:0] en, input logic full,
                      input logic rstn);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (last_rdy[i]) pidx[i]++;
    end
    reset     = rstn;
    fifo_full = full;
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = en[i] && (pidx[i] < len[i]);
      req_data[i*8 +: 8] = base[i] + 8'(pidx[i]);
    end
    #1;
    last_rdy = req_ready;
    if (fifo_write_en && !fifo_full) wq.push_back(fifo_data_in);
  endtask

  task automatic chk_q(input string nm, input logic [7:0] b0,
                       input int n);
    chk({nm, "_len"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      chk({nm, "_dat"}, {24'd0, wq[i]}, {24'd0, b0 + 8'(i)});
    end
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    setup();

    // Reset with all valid, then producer 2 alone sends 0x11..0x16
    tv[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tv[1]  = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tv[2]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h11, 4'b0100};
    tv[3]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h12, 4'b0100};
    tv[4]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h13, 4'b0100};
    tv[5]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h14, 4'b0100};
    tv[6]  = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tv[7]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h15, 4'b0100};
    tv[8]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h16, 4'b0100};
    tv[9]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 8'h17, 4'b0000};
    tv[10] = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};

    base[2] = 8'h11;
    len[2]  = 6;
    for (int v = 0; v < 11; v++) begin
      step(tv[v].en, tv[v].full, tv[v].rstn);
      chk_out($sformatf("single_v%0d", v),
              tv[v].g, tv[v].b, tv[v].we, tv[v].d, tv[v].r);
    end
    chk_q("single_fifo", 8'h11, 6);

    // Fairness: all four valid, five grants of four beats each
    setup();
    for (int i = 0; i < 4; i++) base[i] = 8'(i << 4);
    step(4'b1111, 1'b0, 1'b0);
    chk_out("fair_reset", 4'b0, 1'b0, 1'b0, 8'h00, 4'b0);
    step(4'b1111, 1'b0, 1'b1);
    chk_out("fair_idle0", 4'b0, 1'b0, 1'b0, 8'h00, 4'b0);
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++) begin
        step(4'b1111, 1'b0, 1'b1);
        chk_out($sformatf("fair_g%0d_b%0d", g, k),
                4'(1 << (g % 4)), 1'b1, 1'b1,
                8'(((g % 4) << 4) + 4 * (g / 4) + k),
                4'(1 << (g % 4)));
      end
      step(4'b1111, 1'b0, 1'b1);
      chk_out($sformatf("fair_gap%0d", g),
              4'b0, 1'b0, 1'b0, 8'h00, 4'b0);
    end

    // Full stall for 5 cycles after two beats of producer 1
    setup();
    base[1] = 8'h40;
    len[1]  = 6;
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b1);
    chk_out("stall_idle", 4'b0, 1'b0, 1'b0, 8'h00, 4'b0);
    step(4'b0010, 1'b0, 1'b1);
    chk_out("stall_b0", 4'b0010, 1'b1, 1'b1, 8'h40, 4'b0010);
    step(4'b0010, 1'b0, 1'b1);
    chk_out("stall_b1", 4'b0010, 1'b1, 1'b1, 8'h41, 4'b0010);
    for (int s = 0; s < 5; s++) begin
      step(4'b0010, 1'b1, 1'b1);
      chk_out($sformatf("stall_full%0d", s),
              4'b0010, 1'b1, 1'b0, 8'h42, 4'b0);
    end
    step(4'b0010, 1'b0, 1'b1);
    chk_out("stall_b2", 4'b0010, 1'b1, 1'b1, 8'h42, 4'b0010);
    step(4'b0010, 1'b0, 1'b1);
    chk_out("stall_b3", 4'b0010, 1'b1, 1'b1, 8'h43, 4'b0010);
    step(4'b0010, 1'b0, 1'b1);
    chk_out("stall_rel", 4'b0, 1'b0, 1'b0, 8'h00, 4'b0);
    chk_q("stall_fifo", 8'h40, 4);

    // Early release of producer 1; producer 3 must win over producer 0
    setup();
    base[0] = 8'h30; len[0] = 2;
    base[1] = 8'h50; len[1] = 2;
    base[3] = 8'h70; len[3] = 2;
    step(4'b1010, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b1);
    chk_out("early_idle", 4'b0, 1'b0, 1'b0, 8'h00, 4'b0);
    step(4'b1011, 1'b0, 1'b1);
    chk_out("early_b0", 4'b0010, 1'b1, 1'b1, 8'h50, 4'b0010);
    step(4'b1011, 1'b0, 1'b1);
    chk_out("early_b1", 4'b0010, 1'b1, 1'b1, 8'h51, 4'b0010);
    step(4'b1011, 1'b0, 1'b1);
    chk_out("early_drop", 4'b0010, 1'b1, 1'b0, 8'h52, 4'b0);
    step(4'b1011, 1'b0, 1'b1);
    chk_out("early_gap", 4'b0, 1'b0, 1'b0, 8'h00, 4'b0);
    step(4'b1011, 1'b0, 1'b1);
    chk_out("early_p3", 4'b1000, 1'b1, 1'b1, 8'h70, 4'b1000);

    // Reset mid-burst: held beat 0x82 is written exactly once afterwards
    setup();
    base[2] = 8'h80;
    len[2]  = 4;
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b1);
    chk_out("rst_b0", 4'b0100, 1'b1, 1'b1, 8'h80, 4'b0100);
    step(4'b0100, 1'b0, 1'b1);
    chk_out("rst_b1", 4'b0100, 1'b1, 1'b1, 8'h81, 4'b0100);
    step(4'b0100, 1'b0, 1'b0);
    chk_out("rst_async", 4'b0, 1'b0, 1'b0, 8'h00, 4'b0);
    step(4'b0100, 1'b0, 1'b1);
    chk_out("rst_idle", 4'b0, 1'b0, 1'b0, 8'h00, 4'b0);
    step(4'b0100, 1'b0, 1'b1);
    chk_out("rst_b2", 4'b0100, 1'b1, 1'b1, 8'h82, 4'b0100);
    step(4'b0100, 1'b0, 1'b1);
    chk_out("rst_b3", 4'b0100, 1'b1, 1'b1, 8'h83, 4'b0100);
    step(4'b0100, 1'b0, 1'b1);
    chk_out("rst_drop", 4'b0100, 1'b1, 1'b0, 8'h84, 4'b0);
    chk_q("rst_fifo", 8'h80, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
